// File: rtl/mem_pkg.sv
// Shared definitions for the RAM controller: access-size encodings, FSM states
// and the legality rule for a master request.
package mem_pkg;

  localparam int ADDR_W_DEF = 15;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RWAIT,
    WRITE,
    DONE
  } state_e;

  // A request is rejected for unknown sizes, unsigned stores and misalignment.
  function automatic logic access_illegal(input logic       we,
                                          input logic [1:0] lane,
                                          input logic [2:0] rw_type);
    logic bad;
    case (rw_type)
      RW_B, RW_BU: bad = 1'b0;
      RW_H, RW_HU: bad = lane[0];
      RW_W:        bad = |lane;
      default:     bad = 1'b1;
    endcase
    return bad | (we & rw_type[2]);
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte/halfword lane logic: extracts and extends a load value from a RAM word
// and merges sub-word store data into that word.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  rw_type_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // a value unassigned and infer a latch.
    load_o   = '0;
    merged_o = word_i;
    case (rw_type_i)
      RW_B, RW_BU: begin
        load_o = rw_type_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      RW_H, RW_HU: begin
        load_o = rw_type_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      RW_W: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_ctrl.sv
// Two-master single-port RAM controller with round-robin arbitration,
// sub-word loads and read-modify-write sub-word stores.
module ram_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [2:0]        m0_rw_type,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ready,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [2:0]        m1_rw_type,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              prio_q, prio_d;   // master that wins a tie; 0 favours m0
  logic              we_q, we_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [2:0]        rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       word_q, word_d;
  logic [1:0][31:0]  rdata_q, rdata_d;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W+1:0] sel_addr;
  logic [2:0]        sel_rw;
  logic [31:0]       load_val, merged, done_rdata;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m1_addr[31:ADDR_W+2]};

  mem_lane_unit u_lane (
    .word_i    (word_q),
    .lane_i    (addr_q[1:0]),
    .rw_type_i (rw_q),
    .wdata_i   (wdata_q),
    .load_o    (load_val),
    .merged_o  (merged)
  );

  assign done_rdata = err_q ? '0 : (we_q ? rdata_q[gnt_q] : load_val);

  assign sel      = (m0_req & m1_req) ? prio_q : m1_req;
  assign sel_we   = sel ? m1_we : m0_we;
  assign sel_addr = sel ? m1_addr[ADDR_W+1:0] : m0_addr[ADDR_W+1:0];
  assign sel_rw   = sel ? m1_rw_type : m0_rw_type;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    we_d    = we_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = sel;
          prio_d  = ~sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          rw_d    = sel_rw;
          wdata_d = sel ? m1_wdata : m0_wdata;
          err_d   = access_illegal(sel_we, sel_addr[1:0], sel_rw);
          if (err_d)                      state_d = DONE;
          else if (sel_we && sel_rw == RW_W) state_d = WRITE;
          else                            state_d = READ;
        end
      end
      READ:  state_d = RWAIT;
      RWAIT: begin
        word_d  = ram_rdata;
        state_d = we_q ? WRITE : DONE;
      end
      WRITE: state_d = DONE;
      DONE: begin
        rdata_d[gnt_q] = done_rdata;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rw_q    <= RW_B;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_en    = (state_q == READ) || (state_q == WRITE);
  assign ram_we    = (state_q == WRITE);
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = (state_q == WRITE && rw_q != RW_W) ? merged : wdata_q;

  assign m0_ready = (state_q == DONE) && !gnt_q;
  assign m1_ready = (state_q == DONE) &&  gnt_q;
  assign m0_err   = m0_ready & err_q;
  assign m1_err   = m1_ready & err_q;
  assign m0_rdata = m0_ready ? done_rdata : rdata_q[0];
  assign m1_rdata = m1_ready ? done_rdata : rdata_q[1];

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed scenarios plus randomized single
// accesses against a word-array reference model and a behavioural RAM.
module tb_ram_ctrl;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [31:0]       m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]        m0_rw_type, m1_rw_type;
  logic              m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_rw_type(m0_rw_type),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_rw_type(m1_rw_type),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural synchronous RAM with cycle counters
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  int en_cnt = 0;
  int we_cnt = 0;
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt++;
      if (ram_we) begin
        we_cnt++;
        ram[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata [2];
  int          ref_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 1));
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  function automatic bit ref_legal(input logic we, input logic [31:0] a, input logic [2:0] rw);
    if (rw == 3 || rw == 6 || rw == 7) return 0;
    if (we && rw >= 4) return 0;
    if ((rw == 1 || rw == 5) && (a % 2) != 0) return 0;
    if (rw == 2 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] rw);
    int off;
    logic [31:0] b, h;
    off = int'(a % 4);
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (rw)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] rw, input logic [31:0] wd);
    int off;
    logic [31:0] mask;
    off = int'(a % 4);
    if (rw == 0) begin
      mask = 32'hFF << (8 * off);
      return (w & ~mask) | ((wd & 32'hFF) << (8 * off));
    end else if (rw == 1) begin
      mask = 32'hFFFF << (16 * (off / 2));
      return (w & ~mask) | ((wd & 32'hFFFF) << (16 * (off / 2)));
    end
    return wd;
  endfunction

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a,
                       input logic [2:0] rw, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_rw_type = rw; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_rw_type = rw; m1_wdata = wd;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 32'({ram_en, ram_we, m0_ready, m0_err, m1_ready, m1_err}), 32'h0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'h0);
  endtask

  // One access by a single master; latency counted in cycles after the grant edge.
  task automatic access(input int m, input logic we, input logic [31:0] a, input logic [2:0] rw,
                        input logic [31:0] wd, input string tag);
    bit          legal;
    int          exp_lat, exp_en, exp_we, en0, we0, lat, idx;
    logic [31:0] exp_rd, rd;
    logic        rdy, err, other;
    legal  = ref_legal(we, a, rw);
    idx    = widx(a);
    exp_lat = !legal ? 1 : (!we ? 3 : (rw == 2 ? 2 : 4));
    exp_en  = !legal ? 0 : (!we ? 1 : (rw == 2 ? 1 : 2));
    exp_we  = (legal && we) ? 1 : 0;
    exp_rd  = !legal ? 32'h0 : (we ? ref_rdata[m] : ref_load(ref_word(idx), a, rw));
    err = 1'b0; rd = '0; other = 1'b0;
    @(negedge clk);
    drive(m, 1'b1, we, a, rw, wd);
    drive(1 - m, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    en0 = en_cnt;
    we0 = we_cnt;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      rdy = (m == 0) ? m0_ready : m1_ready;
      if (rdy) begin
        lat   = c;
        err   = (m == 0) ? m0_err : m1_err;
        rd    = (m == 0) ? m0_rdata : m1_rdata;
        other = (m == 0) ? m1_ready : m0_ready;
        break;
      end
      @(posedge clk);
    end
    drive(m, 1'b0, we, a, rw, wd);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      check({tag, "_err"}, 32'(err), 32'(!legal));
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_other_ready"}, 32'(other), 32'h0);
    end
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'({m0_ready, m1_ready}), 32'h0);
    check({tag, "_ram_en_cycles"}, 32'(en_cnt - en0), 32'(exp_en));
    check({tag, "_ram_we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
    ref_last = m;
    ref_rdata[m] = exp_rd;
    if (legal && we) ref_mem[idx] = ref_store(ref_word(idx), a, rw, wd);
  endtask

  initial begin
    int          got, who, exp_who;
    logic [31:0] exp_val, a;
    logic [2:0]  rw;

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;
    ram[8] = 32'hDEAD_BEEF; ref_mem[8] = 32'hDEAD_BEEF;
    ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    access(0, 1'b0, 32'h12, 3'b000, 32'h0, "ld_b_0x12");
    access(0, 1'b0, 32'h12, 3'b100, 32'h0, "ld_bu_0x12");
    access(0, 1'b1, 32'h12, 3'b001, 32'h0000_1234, "st_h_0x12");
    check("st_h_ram_word", ram[4], 32'h1234_AABB);
    access(1, 1'b0, 32'h06, 3'b010, 32'h0, "m1_ld_w_misaligned");

    // Both masters hold load requests; grants must alternate.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h40, 3'b010, 32'h0);
    exp_who = (ref_last == 0) ? 1 : 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(posedge clk);
      #1;
      if (m0_ready || m1_ready) begin
        who = m1_ready ? 1 : 0;
        check("rr_both_ready", 32'({m0_ready, m1_ready}), who ? 32'h1 : 32'h2);
        check("rr_order", 32'(who), 32'(exp_who));
        exp_val = ref_word(who ? widx(32'h40) : widx(32'h10));
        check("rr_rdata", who ? m1_rdata : m0_rdata, exp_val);
        ref_rdata[who] = exp_val;
        ref_last = who;
        exp_who = 1 - who;
        got++;
        if (got == 8) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("rr_completions", 32'(got), 32'd8);
    @(posedge clk);

    // Reset during RWAIT of a byte store must leave the RAM word untouched.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h21, 3'b000, 32'h0000_0055);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m0_req = 1'b0;
    check_idle_outputs("mid_rmw_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rmw_word", ram[8], 32'hDEAD_BEEF);
    ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1;
    access(0, 1'b0, 32'h20, 3'b010, 32'h0, "after_reset_ld_w");

    for (int n = 0; n < 150; n++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFE_0000);
      rw = 3'($urandom_range(0, 7));
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rw, $urandom, "rand");
    end

    for (int i = 0; i < 64; i++) check("final_mem", ram[i], ref_word(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
